// File: rtl/ela_frame_streamer.sv
// ELA frame streamer: reads the reconstructed progressive frame back from
// the result SRAM in raster order and streams it out pixel by pixel.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start                level, sampled only in IDLE (deinterlacer done)
//   mem_ren/mem_addr     SRAM read request, address = row*WIDTH + col
//   mem_rdata            SRAM read data, valid the cycle after mem_ren
//   out_valid/out_ready  pixel handshake; out_data is the head pixel
//   out_sol/out_last     head pixel starts a line / ends the frame
//   busy                 high while reading or draining a frame
//   frame_done           one-cycle pulse after the final accept
//   checksum             sum of accepted pixels, held until next start
module ela_frame_streamer #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 64,
  parameter int AW     = 13,
  parameter int CSW    = 21
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           mem_ren,
  output logic [AW-1:0]  mem_addr,
  input  logic [7:0]     mem_rdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic           out_sol,
  output logic           out_last,
  output logic           busy,
  output logic           frame_done,
  output logic [CSW-1:0] checksum
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [AW-1:0] LAST = AW'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   out_cnt_q, out_cnt_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic            inflight_q, inflight_d;
  logic            rd_idx_q, rd_idx_d;
  logic            wr_idx_q, wr_idx_d;
  logic [1:0][7:0] buf_q, buf_d;
  logic [CSW-1:0]  checksum_q, checksum_d;

  logic       push;
  logic       pop;
  logic [2:0] occ;

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;

  // Buffered plus outstanding reads may never exceed the 2 slots,
  // counting the slot freed by a pop in this same cycle.
  assign occ     = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign mem_ren = (state_q == RUN) && (occ <= 3'd1 + {2'b00, pop});

  assign mem_addr   = rd_ptr_q;
  assign out_data   = out_valid ? buf_q[rd_idx_q] : 8'h00;
  assign out_sol    = out_valid && (out_cnt_q[CW-1:0] == '0);
  assign out_last   = out_valid && (out_cnt_q == LAST);
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);
  assign checksum   = checksum_q;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    out_cnt_d  = out_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    inflight_d = mem_ren;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    buf_d      = buf_q;
    checksum_d = checksum_q;

    if (push) begin
      buf_d[wr_idx_q] = mem_rdata;
      wr_idx_d        = ~wr_idx_q;
    end

    if (pop) begin
      rd_idx_d   = ~rd_idx_q;
      out_cnt_d  = out_cnt_q + AW'(1);
      checksum_d = checksum_q + CSW'(out_data);
    end

    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (mem_ren) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          rd_ptr_d   = '0;
          out_cnt_d  = '0;
          checksum_d = '0;
          rd_idx_d   = 1'b0;
          wr_idx_d   = 1'b0;
        end
      end
      RUN: begin
        if (mem_ren && (rd_ptr_q == LAST)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (out_cnt_q == LAST)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      out_cnt_q  <= '0;
      fifo_cnt_q <= 2'd0;
      inflight_q <= 1'b0;
      rd_idx_q   <= 1'b0;
      wr_idx_q   <= 1'b0;
      buf_q      <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      out_cnt_q  <= out_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      buf_q      <= buf_d;
      checksum_q <= checksum_d;
    end
  end

endmodule

// File: tb/tb_ela_frame_streamer.sv
// Bench for ela_frame_streamer: frame-level scoreboard against a model
// SRAM, table-driven frame scenarios plus stall/reset/restart sequences.
module tb_ela_frame_streamer;

  localparam int WIDTH  = 128;
  localparam int HEIGHT = 64;
  localparam int AW     = 13;
  localparam int CSW    = 21;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic           clk;
  logic           rst;
  logic           start;
  logic           mem_ren;
  logic [AW-1:0]  mem_addr;
  logic [7:0]     mem_rdata;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_data;
  logic           out_sol;
  logic           out_last;
  logic           busy;
  logic           frame_done;
  logic [CSW-1:0] checksum;

  ela_frame_streamer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW), .CSW(CSW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sol(out_sol), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .checksum(checksum)
  );

  logic [7:0] mem [0:NPIX-1];
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

  typedef struct {
    int fill;
    int rmode;
    bit poke;
    int exp_sum;
    int exp_span;
  } vec_t;

  vec_t vecs [4];

  int n_chk;
  int n_pass;

  int acc_idx, issued, first_v, last_acc;
  int done_cnt, done_cyc, ovf_cnt, busy_bad;
  logic [CSW-1:0] done_cs;
  bit done_seen, in_stall, stall_done;
  int stall_left;

  task automatic check(input string name, input bit ok,
                       input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fill_mem(input int mode, output int sum);
    sum = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (mode == 0) mem[i] = i[7:0];
      else if (mode == 1) mem[i] = 8'hFF;
      else mem[i] = 8'($urandom);
      sum += int'(mem[i]);
    end
  endtask

  task automatic clear_model();
    acc_idx = 0; issued = 0; first_v = -1; last_acc = -1;
    done_cnt = 0; done_cyc = -1; ovf_cnt = 0; busy_bad = 0;
    done_cs = '0; done_seen = 0; in_stall = 0;
    stall_done = 0; stall_left = 0;
  endtask

  task automatic sample();
    logic [9:0] got, exp;
    if (first_v < 0 && out_valid) first_v = cyc;
    if (mem_ren) issued++;
    if (in_stall)
      check("stall_hold", out_valid && out_data == 8'h2C && !mem_ren,
            {out_valid, out_data, mem_ren}, {1'b1, 8'h2C, 1'b0});
    if (out_valid && out_ready) begin
      if (acc_idx >= NPIX) begin
        check("extra_beat", 1'b0, acc_idx, NPIX - 1);
      end else begin
        exp = {mem[acc_idx], (acc_idx % WIDTH) == 0, acc_idx == NPIX - 1};
        got = {out_data, out_sol, out_last};
        check("beat", got == exp, got, exp);
      end
      acc_idx++;
      last_acc = cyc;
    end
    if (issued - acc_idx > 2) ovf_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_cs = checksum;
      done_seen = 1;
      if (busy) busy_bad++;
    end else if (!busy) begin
      busy_bad++;
    end
  endtask

  task automatic run_frame(input int rmode, input bit poke,
                           input int abort_at, input bit hold,
                           input bit already, input int exp_sum,
                           input int exp_span);
    int k;
    clear_model();
    k = -1;
    if (already) begin
      k = cyc;
    end else begin
      @(posedge clk); #1;
      start = 1'b1;
      for (int w = 0; w < 10; w++) begin
        @(posedge clk); #1;
        if (busy) begin
          k = cyc;
          break;
        end
      end
      if (k < 0) begin
        check("start_timeout", 1'b0, 0, 1);
        start = 1'b0;
        return;
      end
    end
    for (int i = 0; i < 40000 && !done_seen; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (abort_at >= 0 && acc_idx >= abort_at) begin
        rst = 1'b1;
        #1;
        check("async_reset",
              {out_valid, out_data, out_sol, out_last, mem_ren, mem_addr,
               busy, frame_done, checksum} == '0,
              {out_valid, out_data, out_sol, out_last, mem_ren, mem_addr,
               busy, frame_done, checksum}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset", {busy, out_valid, checksum} == '0,
              {busy, out_valid, checksum}, 0);
        return;
      end
      if (i == 0)
        check("first_issue", mem_ren && mem_addr == '0,
              {mem_ren, mem_addr}, {1'b1, 13'd0});
      in_stall = 0;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (i % 2 == 0);
        2: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stall_done && out_valid && acc_idx == 300) begin
            stall_left = 10;
            stall_done = 1;
          end
          out_ready = (stall_left == 0);
          in_stall = (stall_left != 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      start = (poke && i % 500 == 100 && i < 8000) ? 1'b1 : hold;
      @(negedge clk);
      sample();
    end
    in_stall = 0;
    if (!done_seen) begin
      check("done_timeout", 1'b0, 0, 1);
      return;
    end
    @(posedge clk); #1;
    check("beat_count", acc_idx == NPIX, acc_idx, NPIX);
    check("first_valid_lat", first_v - k == 2, first_v - k, 2);
    if (exp_span >= 0)
      check("no_gaps", last_acc - first_v == exp_span,
            last_acc - first_v, exp_span);
    check("done_after_last", done_cyc == last_acc + 1,
          done_cyc - last_acc, 1);
    check("done_pulse", done_cnt == 1 && !frame_done,
          {done_cnt[7:0], frame_done}, {8'd1, 1'b0});
    check("checksum", int'(done_cs) == exp_sum, done_cs, exp_sum);
    check("idle_hold", !busy && int'(checksum) == exp_sum,
          {busy, checksum}, exp_sum);
    check("credit", ovf_cnt == 0, ovf_cnt, 0);
    check("busy", busy_bad == 0, busy_bad, 0);
  endtask

  initial begin
    int s;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    clear_model();

    vecs[0] = '{fill: 0, rmode: 0, poke: 0, exp_sum: 1044480, exp_span: 8191};
    vecs[1] = '{fill: 0, rmode: 1, poke: 0, exp_sum: 1044480, exp_span: -1};
    vecs[2] = '{fill: 1, rmode: 0, poke: 1, exp_sum: 2088960, exp_span: 8191};
    vecs[3] = '{fill: 2, rmode: 2, poke: 0, exp_sum: -1, exp_span: -1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {out_valid, out_data, out_sol, out_last, mem_ren, mem_addr,
           busy, frame_done, checksum} == '0,
          {out_valid, out_data, out_sol, out_last, mem_ren, mem_addr,
           busy, frame_done, checksum}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 4; v++) begin
      fill_mem(vecs[v].fill, s);
      if (vecs[v].exp_sum >= 0) s = vecs[v].exp_sum;
      run_frame(vecs[v].rmode, vecs[v].poke, -1, 1'b0, 1'b0,
                s, vecs[v].exp_span);
    end

    fill_mem(0, s);
    run_frame(3, 1'b0, -1, 1'b0, 1'b0, 1044480, -1);

    run_frame(0, 1'b0, 1000, 1'b0, 1'b0, 1044480, -1);

    fill_mem(2, s);
    run_frame(0, 1'b0, -1, 1'b1, 1'b0, s, 8191);
    @(posedge clk); #1;
    check("restart_clear", busy && checksum == '0,
          {busy, checksum}, {1'b1, 21'd0});
    run_frame(0, 1'b0, -1, 1'b1, 1'b1, s, 8191);
    start = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ela_frame_streamer.md
Name: ela_frame_streamer

Overview:
- Downstream stage of the edge-based line-average deinterlacer. Once the deinterlacer signals frame completion, this block reads the reconstructed 128x64 progressive frame back from the shared result SRAM in raster order.
- It streams the frame out as an 8-bit pixel stream with a valid/ready handshake, start-of-line and end-of-frame markers, and a frame checksum.
- A 2-entry buffer absorbs the 1-cycle SRAM read latency so that full throughput is kept under backpressure.

Parameters:
- WIDTH, 128, pixels per line (power of two)
- HEIGHT, 64, lines per frame
- AW, 13, SRAM address width; must satisfy 2^AW >= WIDTH*HEIGHT
- CSW, 21, checksum width (8192*255 = 2,088,960 < 2^21)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; sampled only in IDLE; connect to the deinterlacer done output
- mem_ren  out  1  SRAM read enable (combinational from state/credit)
- mem_addr  out  AW  SRAM read address = row*WIDTH + col
- mem_rdata  in  8  SRAM read data, valid in the cycle after mem_ren
- out_valid  out  1  pixel available
- out_ready  in  1  consumer accepts pixel when out_valid && out_ready
- out_data  out  8  pixel value
- out_sol  out  1  head pixel has col==0
- out_last  out  1  head pixel is index WIDTH*HEIGHT-1
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse after the final accept
- checksum  out  CSW  sum of accepted pixels; stable from frame_done until the next start

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sol=0, out_last=0, mem_ren=0, mem_addr=0, busy=0, frame_done=0, checksum=0. Internal state is cleared as follows: state=IDLE, rd_ptr=0, out_cnt=0, fifo_cnt=0, inflight=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN: start=1 at a clock edge. On that edge, rd_ptr=0, out_cnt=0, checksum=0.
- In IDLE and DONE, start is ignored except as the IDLE entry condition. A start pulse during RUN or DRAIN has no effect.
- Read issue rule, evaluated in RUN only:
  - mem_ren=1 when fifo_cnt + inflight - pop <= 1, where pop = out_valid && out_ready in the same cycle.
  - When mem_ren=1, mem_addr=rd_ptr and rd_ptr increments.
  - inflight is 1 in the cycle after an issue. Returned data is written to the FIFO tail on the following edge.
- RUN to DRAIN: on the edge that issues address WIDTH*HEIGHT-1.
- DRAIN to DONE: on the edge where the last pixel (out_cnt = WIDTH*HEIGHT-1) is accepted.
- DONE: frame_done=1 for exactly one cycle, busy=0, then go to IDLE.
- FIFO behaviour:
  - Depth is 2. out_data, out_sol and out_last come from the head entry.
  - Head fields are held stable while out_valid && !out_ready.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - Overflow is impossible by the credit rule. A bench assertion checks fifo_cnt <= 2.
- Output flags:
  - out_sol = (out_cnt % WIDTH == 0).
  - out_last = (out_cnt == WIDTH*HEIGHT-1).
  - out_cnt and checksum update only on accept.
- Latency: the start edge is edge k. mem_ren rises in the cycle after edge k, and out_valid rises after edge k+2.
- Throughput: with out_ready held at 1, the block delivers one pixel per cycle. The full frame takes WIDTH*HEIGHT consecutive accept cycles, and frame_done follows on the next cycle.
- Checksum arithmetic: unsigned, zero-extended 8-bit addends. No wrap occurs at the default parameters.
- Reset mid-operation: all outputs return to their reset values immediately. Any in-flight read data is discarded. The next start begins again at address 0.

Test Plan:
- Memory preloaded with data = addr[7:0], out_ready=1:
  - 8192 accepts in order with no gaps; first out_valid 2 cycles after the start edge.
  - out_sol on every 128th beat; out_last only on beat 8191.
  - checksum = 1,044,480; frame_done one cycle after the last beat.
- out_ready toggles 1,0,1,0 throughout the frame:
  - Every pixel is delivered exactly once and in order.
  - Never more than 2 entries buffered plus in-flight; checksum = 1,044,480.
- out_ready held low for 10 cycles while pixel 300 (0x2C) is at the head:
  - out_data stays 0x2C and out_valid stays high.
  - mem_ren drops after the buffer fills.
  - Streaming resumes with no skipped or duplicated pixels.
- Memory filled with 0xFF:
  - checksum = 2,088,960.
  - start pulses during RUN are ignored; busy stays high until DONE.
- rst asserted after 1000 accepts:
  - All outputs go to 0 asynchronously.
  - A subsequent start restarts streaming at address 0 with checksum cleared.
- start held high continuously:
  - After DONE and IDLE, a second frame begins.
  - checksum is valid in the frame_done cycle and clears on the restart edge.
